// File: rtl/frame_buffer_pkg.sv
// rtl/frame_buffer_pkg.sv - shared sizes, state encoding and row-offset helper for the frame buffer
package frame_buffer_pkg;

  localparam int CW        = 12;
  localparam int H_PIX     = 80;
  localparam int V_PIX     = 60;
  localparam int FB_WORDS  = H_PIX * V_PIX;
  localparam int MEM_WORDS = 2 * FB_WORDS;
  localparam int AW        = $clog2(MEM_WORDS);

  localparam logic [CW-1:0] CLR_COLOR = 12'h000;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    RUN,
    WAIT_SWAP,
    CLEAR_BACK
  } fb_state_t;

  // Row offset y*H_PIX; the default width of 80 reduces to two shifts and an add.
  function automatic logic [AW-1:0] row_base(input logic [5:0] y);
    logic [AW-1:0] yy;
    yy = AW'(y);
    if (H_PIX == 80) return (yy << 6) + (yy << 4);
    else return yy * AW'(H_PIX);
  endfunction

  function automatic logic [AW-1:0] bank_base(input logic bank);
    return bank ? AW'(FB_WORDS) : '0;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port synchronous RAM, one write port and one registered read port
module fb_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 9600,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered pixel store swapping banks on the vs falling edge
module frame_buffer
  import frame_buffer_pkg::*;
(
  input  logic          vga_clk,
  input  logic          clrn,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [6:0]    wr_x,
  input  logic [5:0]    wr_y,
  input  logic [CW-1:0] wr_data,
  input  logic          frame_done,
  input  logic          vs,
  input  logic [6:0]    col_addr,
  input  logic [5:0]    row_addr,
  output logic [CW-1:0] dout,
  output logic          front_sel,
  output logic          swap_done,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    drop_cnt,
  output logic          clearing
);

  fb_state_t     state, state_nx;
  logic [AW-1:0] clr_ptr;
  logic          vs_q;
  logic          vs_fall;
  logic          swap;
  logic          wr_in_range;
  logic          rd_in_range;
  logic          rd_ok;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [CW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [CW-1:0] ram_rdata;

  assign vs_fall     = vs_q & ~vs;
  assign wr_in_range = (wr_x < 7'(H_PIX)) && (wr_y < 6'(V_PIX));
  assign rd_in_range = (col_addr < 7'(H_PIX)) && (row_addr < 6'(V_PIX));
  assign ram_raddr   = rd_in_range ?
                       bank_base(front_sel) + row_base(row_addr) + AW'(col_addr) : '0;
  assign dout        = rd_ok ? ram_rdata : '0;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) state <= CLEAR_ALL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    clearing  = 1'b0;
    swap      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = clr_ptr;
    ram_wdata = CLR_COLOR;
    case (state)
      CLEAR_ALL: begin
        clearing = 1'b1;
        ram_we   = 1'b1;
        if (clr_ptr == AW'(MEM_WORDS - 1)) state_nx = RUN;
      end
      RUN: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = bank_base(~front_sel) + row_base(wr_y) + AW'(wr_x);
          ram_wdata = wr_data;
        end
        if (frame_done) state_nx = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vs_fall) begin
          swap     = 1'b1;
          state_nx = CLEAR_BACK;
        end
      end
      CLEAR_BACK: begin
        // front_sel has already toggled, so ~front_sel is the bank just retired from display
        clearing  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = bank_base(~front_sel) + clr_ptr;
        if (clr_ptr == AW'(FB_WORDS - 1)) state_nx = RUN;
      end
      default: state_nx = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      clr_ptr   <= '0;
      vs_q      <= 1'b1;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      rd_ok     <= 1'b0;
    end else begin
      vs_q      <= vs;
      swap_done <= swap;
      rd_ok     <= rd_in_range;
      if (clearing) clr_ptr <= (state_nx == state) ? clr_ptr + 1'b1 : '0;
      else          clr_ptr <= '0;
      if (swap) begin
        front_sel <= ~front_sel;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (state == RUN && wr_valid && !wr_in_range && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  fb_ram #(
    .DW   (CW),
    .DEPTH(MEM_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk  (vga_clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule
